fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Drives the program counter register: consumes its current value, issues instruction-memory reads at that address, and writes back PC+PC_INC or a redirect target.
- Buffers fetched instructions in a 2-entry FIFO with a valid/ready handshake toward decode.
- Supports single-cycle redirect (branch/jump) with flush and a discard of any in-flight read.

Parameters:
ADDR_WIDTH, 16, width of PC and instruction address
INSTR_WIDTH, 32, width of an instruction word
PC_INC, 1, increment applied to PC per sequential fetch (word-addressed memory)

Ports:
clk  input  1  clock; all state changes on posedge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk)
pc_cur  input  ADDR_WIDTH  current PC from the program counter register
pc_write  output  1  write enable to the program counter register
pc_next  output  ADDR_WIDTH  value to load into the program counter register
imem_req  output  1  instruction memory read request
imem_addr  output  ADDR_WIDTH  read address, valid while imem_req=1
imem_ack  input  1  memory has returned imem_rdata this cycle
imem_rdata  input  INSTR_WIDTH  read data, valid when imem_ack=1
redirect  input  1  one-cycle pulse: replace PC and flush
redirect_target  input  ADDR_WIDTH  new PC when redirect=1
inst_valid  output  1  FIFO head is valid
inst_data  output  INSTR_WIDTH  FIFO head instruction
inst_pc  output  ADDR_WIDTH  address the head instruction was fetched from
inst_ready  input  1  decode accepts head this cycle

Behaviour:
- Reset (reset=0 at posedge): state=IDLE, FIFO count=0, addr_hold=0. inst_valid=0, imem_req=0, pc_write=0, inst_data=0, inst_pc=0, pc_next=0. Reset mid-request abandons the request; a late ack is ignored.
- States: IDLE (no request), BUSY (request outstanding at pc_cur), DISCARD (request outstanding whose data must be dropped).
- imem_req=1 in BUSY and DISCARD. imem_addr=pc_cur in BUSY and addr_hold in DISCARD. addr_hold captures pc_cur every cycle in BUSY.
- Memory protocol: req and addr are held stable until ack. Ack may arrive in the same cycle req rises or any later cycle. There is only one outstanding request.
- IDLE -> BUSY when FIFO count<2 (registered, so at least one idle cycle after reset or after full).
- BUSY with imem_ack and no redirect:
  - push {pc_cur, imem_rdata}.
  - pc_write=1, pc_next=pc_cur+PC_INC, truncated mod 2^ADDR_WIDTH (0xFFFF wraps to 0x0000).
  - next state BUSY if post-push/post-pop count<2, else IDLE.
  - The next request uses the updated pc_cur in the following cycle.
- pc_write and pc_next are combinational from imem_ack/redirect/state. pc_write=0 otherwise.
- Redirect (any state):
  - pc_write=1, pc_next=redirect_target. The FIFO is cleared at the posedge, so inst_valid=0 next cycle and any same-cycle pop is void.
  - BUSY without ack -> DISCARD.
  - BUSY with ack -> data dropped, no push, -> BUSY.
  - IDLE -> BUSY.
  - DISCARD without ack -> stays DISCARD. DISCARD with ack -> BUSY.
  - Redirect has priority over the sequential PC update.
- DISCARD with imem_ack and no redirect: data dropped, no pc_write, -> BUSY (fetches at the redirected pc_cur).
- FIFO: 2 entries, head drives inst_*. Pop when inst_valid&inst_ready. Push and pop in the same cycle keeps count; no push when count=2 (guaranteed by state). Outputs stay stable while inst_valid=1 and inst_ready=0.
- Latency: ack at cycle N -> inst_valid=1 at N+1 (if FIFO was empty).

Test Plan:
- Reset then ack every cycle when req=1, inst_ready=1, pc starting at 0 -> imem_addr 0,1,2,3 on successive requests; inst_pc 0,1,2 with matching rdata; pc_write pulses with pc_next=1,2,3.
- inst_ready=0, ack immediate -> two pushes, then IDLE with imem_req=0, inst_valid=1, head stable; raise inst_ready one cycle -> IDLE->BUSY the next cycle, new request issued.
- Redirect to 0x0040 while BUSY with ack delayed 3 cycles -> pc_next=0x0040, FIFO flushed, DISCARD holds old imem_addr; on ack, data dropped and no pc_write; next request at 0x0040.
- Redirect to 0x0100 in the same cycle as ack -> pc_next=0x0100 (not pc+1), no push, next request at 0x0100.
- pc_cur=0xFFFF, ack -> pc_next=0x0000, inst_pc=0xFFFF.
- Assert reset=0 mid-request with 1 FIFO entry -> next cycle inst_valid=0, imem_req=0, pc_write=0; ack during reset is ignored.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: drives the external PC register, issues single-outstanding
// instruction-memory reads and buffers returned words in a 2-entry FIFO toward decode.
module fetch_unit #(
    parameter int ADDR_WIDTH  = 16,
    parameter int INSTR_WIDTH = 32,
    parameter int PC_INC      = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  pc_cur,
    output logic                   pc_write,
    output logic [ADDR_WIDTH-1:0]  pc_next,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   redirect,
    input  logic [ADDR_WIDTH-1:0]  redirect_target,
    output logic                   inst_valid,
    output logic [INSTR_WIDTH-1:0] inst_data,
    output logic [ADDR_WIDTH-1:0]  inst_pc,
    input  logic                   inst_ready
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             count_q, count_d;
    logic [ADDR_WIDTH-1:0]  addr_hold_q, addr_hold_d;
    logic [ADDR_WIDTH-1:0]  pc_mem_q   [2];
    logic [ADDR_WIDTH-1:0]  pc_mem_d   [2];
    logic [INSTR_WIDTH-1:0] data_mem_q [2];
    logic [INSTR_WIDTH-1:0] data_mem_d [2];

    logic       push;
    logic       pop;
    logic       flush;
    logic [1:0] count_after_pop;

    assign inst_valid = (count_q != 2'd0);
    assign inst_data  = data_mem_q[0];
    assign inst_pc    = pc_mem_q[0];
    assign pop        = inst_valid && inst_ready;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        addr_hold_d     = addr_hold_q;
        pc_mem_d        = pc_mem_q;
        data_mem_d      = data_mem_q;
        pc_write        = 1'b0;
        pc_next         = '0;
        imem_req        = 1'b0;
        imem_addr       = '0;
        push            = 1'b0;
        flush           = 1'b0;
        count_after_pop = 2'd0;

        case (state_q)
            ST_IDLE: begin
                if (redirect || (count_q != 2'd2)) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                imem_req    = 1'b1;
                imem_addr   = pc_cur;
                addr_hold_d = pc_cur;
                if (redirect) begin
                    state_d = imem_ack ? ST_BUSY : ST_DISCARD;
                end else if (imem_ack) begin
                    push     = 1'b1;
                    pc_write = 1'b1;
                    pc_next  = pc_cur + ADDR_WIDTH'(PC_INC);
                end
            end
            ST_DISCARD: begin
                // pc_cur already holds the redirect target; the bus must keep the old address.
                imem_req  = 1'b1;
                imem_addr = addr_hold_q;
                if (imem_ack) begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (redirect) begin
            pc_write = 1'b1;
            pc_next  = redirect_target;
            flush    = 1'b1;
        end

        if (flush) begin
            count_d = 2'd0;
        end else begin
            count_after_pop = count_q - {1'b0, pop};
            if (pop) begin
                pc_mem_d[0]   = pc_mem_q[1];
                data_mem_d[0] = data_mem_q[1];
            end
            if (push) begin
                pc_mem_d[count_after_pop[0]]   = pc_cur;
                data_mem_d[count_after_pop[0]] = imem_rdata;
            end
            count_d = count_after_pop + {1'b0, push};
        end

        if (push) begin
            state_d = (count_d == 2'd2) ? ST_IDLE : ST_BUSY;
        end

        // A late ack arriving while reset is held must not move the PC.
        if (!reset) begin
            pc_write = 1'b0;
            pc_next  = '0;
        end
    end

    // NOTE: the two FIFO slots are reset too, because decode sees inst_data/inst_pc as 0
    // straight out of reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            count_q     <= 2'd0;
            addr_hold_q <= '0;
            pc_mem_q    <= '{default: '0};
            data_mem_q  <= '{default: '0};
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            addr_hold_q <= addr_hold_d;
            pc_mem_q    <= pc_mem_d;
            data_mem_q  <= data_mem_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic, checked against a
// queue-based model of fetch, redirect and decode handshake.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc_cur;
    logic        pc_write;
    logic [15:0] pc_next;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [15:0] redirect_target;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [15:0] inst_pc;
    logic        inst_ready;

    fetch_unit #(.ADDR_WIDTH(16), .INSTR_WIDTH(32), .PC_INC(1)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_cur          (pc_cur),
        .pc_write        (pc_write),
        .pc_next         (pc_next),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .inst_valid      (inst_valid),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .inst_ready      (inst_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [31:0] data;
    } entry_t;

    // Model: fetched words awaiting decode, whether a read is outstanding, and
    // whether that read's data is to be thrown away after a redirect.
    entry_t      m_q[$];
    bit          m_busy;
    bit          m_drop;
    logic [15:0] m_hold;

    int total = 0;
    int bad   = 0;

    logic        pcw_s = 1'b0;
    logic [15:0] pcn_s = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle. ack_mode: 0 = never ack, 1 = ack whenever requested, 2 = random ack.
    task automatic step(input bit rst_n, input bit rdr, input logic [15:0] tgt,
                        input int ack_mode, input bit rdy);
        bit          e_valid;
        bit          e_pcw;
        logic [15:0] e_pcn;
        bit          popped;
        bit          accepted;
        int          size_before;
        entry_t      e;
        @(negedge clk);
        if (pcw_s) pc_cur = pcn_s;
        reset           = rst_n;
        redirect        = rdr;
        redirect_target = tgt;
        inst_ready      = rdy;
        #1;
        imem_ack   = imem_req && ((ack_mode == 1) || ((ack_mode == 2) && ($urandom_range(1) == 1)));
        imem_rdata = $urandom;
        #1;

        e_valid = (m_q.size() != 0);
        if (!rst_n) begin
            e_pcw = 1'b0;
            e_pcn = '0;
        end else if (rdr) begin
            e_pcw = 1'b1;
            e_pcn = tgt;
        end else if (m_busy && !m_drop && imem_ack) begin
            e_pcw = 1'b1;
            e_pcn = pc_cur + 16'd1;
        end else begin
            e_pcw = 1'b0;
            e_pcn = '0;
        end

        check("imem_req", imem_req, m_busy);
        if (m_busy) check("imem_addr", imem_addr, m_drop ? m_hold : pc_cur);
        check("inst_valid", inst_valid, e_valid);
        if (e_valid) begin
            check("inst_data", inst_data, m_q[0].data);
            check("inst_pc", inst_pc, m_q[0].pc);
        end
        check("pc_write", pc_write, e_pcw);
        if (e_pcw) check("pc_next", pc_next, e_pcn);
        pcw_s = pc_write;
        pcn_s = pc_next;

        if (!rst_n) begin
            m_q.delete();
            m_busy = 0;
            m_drop = 0;
            m_hold = '0;
        end else begin
            popped      = e_valid && rdy;
            accepted    = m_busy && !m_drop && imem_ack && !rdr;
            size_before = m_q.size();
            if (rdr) begin
                m_q.delete();
            end else begin
                if (popped) void'(m_q.pop_front());
                if (accepted) begin
                    e.pc   = pc_cur;
                    e.data = imem_rdata;
                    m_q.push_back(e);
                end
            end
            if (!m_busy) begin
                if (rdr || size_before < 2) begin
                    m_busy = 1;
                    m_drop = 0;
                end
            end else if (m_drop) begin
                if (imem_ack) m_drop = 0;
            end else begin
                m_hold = pc_cur;
                if (rdr) begin
                    if (!imem_ack) m_drop = 1;
                end else if (imem_ack) begin
                    m_busy = (m_q.size() < 2);
                end
            end
        end
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 20 && !imem_req; i++) step(1, 0, '0, 0, 1);
        check(tag, imem_req, 1'b1);
    endtask

    initial begin
        reset           = 1'b0;
        pc_cur          = '0;
        imem_ack        = 1'b0;
        imem_rdata      = '0;
        redirect        = 1'b0;
        redirect_target = '0;
        inst_ready      = 1'b0;
        m_busy          = 0;
        m_drop          = 0;
        m_hold          = '0;

        step(0, 0, '0, 0, 0);
        step(0, 0, '0, 0, 0);
        check("rst_inst_data", inst_data, 32'd0);
        check("rst_inst_pc", inst_pc, 16'd0);
        check("rst_pc_next", pc_next, 16'd0);

        // Sequential fetch from 0 with immediate acks and decode always ready.
        pc_cur = '0;
        for (int i = 0; i < 8; i++) step(1, 0, '0, 1, 1);

        // Decode stalls: FIFO fills, fetch idles, then a single pop restarts it.
        for (int i = 0; i < 6; i++) step(1, 0, '0, 1, 0);
        check("full_valid", inst_valid, 1'b1);
        check("full_idle", imem_req, 1'b0);
        step(1, 0, '0, 1, 1);
        for (int i = 0; i < 3; i++) step(1, 0, '0, 0, 0);
        check("restart_req", imem_req, 1'b1);

        // Redirect while a request is outstanding; ack arrives 3 cycles later.
        for (int i = 0; i < 4; i++) step(1, 0, '0, 0, 1);
        wait_req("wait_req_a");
        step(1, 1, 16'h0040, 0, 1);
        step(1, 0, '0, 0, 1);
        step(1, 0, '0, 0, 1);
        step(1, 0, '0, 1, 1);
        step(1, 0, '0, 0, 1);
        check("redirect_addr", imem_addr, 16'h0040);
        for (int i = 0; i < 3; i++) step(1, 0, '0, 1, 1);

        // Redirect coinciding with an ack.
        wait_req("wait_req_b");
        step(1, 1, 16'h0100, 1, 1);
        step(1, 0, '0, 0, 1);
        check("redirect_ack_addr", imem_addr, 16'h0100);
        for (int i = 0; i < 3; i++) step(1, 0, '0, 1, 1);

        // PC wrap from 0xFFFF to 0x0000.
        wait_req("wait_req_c");
        step(1, 1, 16'hFFFF, 1, 1);
        step(1, 0, '0, 0, 0);
        check("wrap_addr", imem_addr, 16'hFFFF);
        step(1, 0, '0, 1, 0);
        step(1, 0, '0, 0, 0);
        check("wrap_inst_pc", inst_pc, 16'hFFFF);
        check("wrap_pc_cur", pc_cur, 16'h0000);

        // Reset with one buffered entry and a request outstanding; ack lands during reset.
        step(1, 0, '0, 0, 0);
        step(0, 0, '0, 1, 0);
        step(1, 0, '0, 0, 0);
        check("rst_mid_valid", inst_valid, 1'b0);
        check("rst_mid_req", imem_req, 1'b0);

        // Random traffic with occasional redirects.
        pc_cur = 16'($urandom);
        for (int i = 0; i < 400; i++) begin
            step(1, ($urandom_range(15) == 0), 16'($urandom), 2, ($urandom_range(9) < 7));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
